// File: rtl/brq_pkg.sv
// Shared types and helpers for the branch resolve queue: entry layout,
// default fall-through offset and the mispredict check.
package brq_pkg;

    localparam int          GHR_MAX            = 32;
    localparam logic [31:0] FALLTHRU_BYTES_DEF = 32'd8;

    typedef struct packed {
        logic [31:0]        pc;
        logic               pred_take;
        logic [31:0]        pred_target;
        logic [GHR_MAX-1:0] ghr;
    } brq_entry_t;

    // Wrong direction, or right "taken" direction but to the wrong place.
    function automatic logic brq_mispredict(input logic        pred_take,
                                            input logic [31:0] pred_target,
                                            input logic        res_take,
                                            input logic [31:0] res_target);
        return (pred_take != res_take) | (res_take & (pred_target != res_target));
    endfunction

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Predictor/datapath <-> branch resolve queue bundle. Optional perf counters
// appear when BRQ_PERF_CNT_EN is defined.
interface branch_resolve_queue_if #(parameter int GHR_LENGTH = 8);
    logic                  enq_valid;
    logic [31:0]           enq_pc;
    logic                  enq_pred_take;
    logic [31:0]           enq_pred_target;
    logic [GHR_LENGTH-1:0] enq_ghr;
    logic                  res_valid;
    logic                  res_take;
    logic [31:0]           res_target;
    logic                  full;
    logic                  redirect_valid;
    logic [31:0]           redirect_pc;
    logic [GHR_LENGTH-1:0] ghr_restore;
    logic                  upd_valid;
    logic [31:0]           upd_pc;
    logic                  upd_take;
    logic [GHR_LENGTH-1:0] upd_ghr;
    logic                  err_underflow;
`ifdef BRQ_PERF_CNT_EN
    logic [31:0]           perf_branches;
    logic [31:0]           perf_mispred;
`endif

    modport master (
        output enq_valid, enq_pc, enq_pred_take, enq_pred_target, enq_ghr,
               res_valid, res_take, res_target,
        input  full, redirect_valid, redirect_pc, ghr_restore,
               upd_valid, upd_pc, upd_take, upd_ghr, err_underflow
`ifdef BRQ_PERF_CNT_EN
      , input  perf_branches, perf_mispred
`endif
    );

    modport slave (
        input  enq_valid, enq_pc, enq_pred_take, enq_pred_target, enq_ghr,
               res_valid, res_take, res_target,
        output full, redirect_valid, redirect_pc, ghr_restore,
               upd_valid, upd_pc, upd_take, upd_ghr, err_underflow
`ifdef BRQ_PERF_CNT_EN
      , output perf_branches, perf_mispred
`endif
    );
endinterface

// File: rtl/brq_fifo.sv
// Circular buffer of in-flight branches with a squash that empties it while
// the head entry is being popped.
module brq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    input  logic         squash,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign rdata   = mem_q[head_q];
    // A squashing cycle is a wrong-path cycle, so its enqueue never lands.
    assign do_push = push & ~full & ~squash;
    assign do_pop  = pop & ~empty;

    always_comb begin
        head_d  = head_q + PW'(do_pop);
        tail_d  = tail_q + PW'(do_push);
        count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        if (squash) begin
            tail_d  = head_q + PW'(1);
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[tail_q] <= wdata;
    end
endmodule

// File: rtl/branch_resolve_queue.sv
// Records D-stage predictions, checks them at E resolve and drives the
// registered M-stage redirect and predictor update. BRQ_PERF_CNT_EN adds counters.
module branch_resolve_queue
    import brq_pkg::*;
#(
    parameter int          DEPTH          = 4,
    parameter int          GHR_LENGTH     = 8,
    parameter logic [31:0] FALLTHRU_BYTES = FALLTHRU_BYTES_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    branch_resolve_queue_if.slave  bus
);
    brq_entry_t            wr_entry, head_entry;
    logic                  fifo_full, fifo_empty, res_fire, mispred;
    logic [GHR_LENGTH-1:0] ghr_shift;
    logic                  unused_ghr;

    logic                  redirect_valid_q, redirect_valid_d;
    logic [31:0]           redirect_pc_q, redirect_pc_d;
    logic [GHR_LENGTH-1:0] ghr_restore_q, ghr_restore_d;
    logic                  upd_valid_q, upd_valid_d;
    logic [31:0]           upd_pc_q, upd_pc_d;
    logic                  upd_take_q, upd_take_d;
    logic [GHR_LENGTH-1:0] upd_ghr_q, upd_ghr_d;
    logic                  err_underflow_q, err_underflow_d;

    always_comb begin
        wr_entry.pc          = bus.enq_pc;
        wr_entry.pred_take   = bus.enq_pred_take;
        wr_entry.pred_target = bus.enq_pred_target;
        wr_entry.ghr         = GHR_MAX'(bus.enq_ghr);
    end

    assign res_fire  = bus.res_valid & ~fifo_empty;
    assign mispred   = res_fire & brq_mispredict(head_entry.pred_take, head_entry.pred_target,
                                                 bus.res_take, bus.res_target);
    assign ghr_shift = {head_entry.ghr[GHR_LENGTH-2:0], bus.res_take};
    assign unused_ghr = ^head_entry.ghr;

    brq_fifo #(.DEPTH(DEPTH), .W($bits(brq_entry_t))) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (bus.enq_valid),
        .wdata  (wr_entry),
        .pop    (res_fire),
        .squash (mispred),
        .rdata  (head_entry),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Payloads are zeroed when their strobe is low so every output is a clean pulse.
    always_comb begin
        redirect_valid_d = mispred;
        redirect_pc_d    = '0;
        ghr_restore_d    = '0;
        if (mispred) begin
            redirect_pc_d = bus.res_take ? bus.res_target : head_entry.pc + FALLTHRU_BYTES;
            ghr_restore_d = ghr_shift;
        end
        upd_valid_d     = res_fire;
        upd_pc_d        = res_fire ? head_entry.pc : '0;
        upd_take_d      = res_fire & bus.res_take;
        upd_ghr_d       = res_fire ? head_entry.ghr[GHR_LENGTH-1:0] : '0;
        err_underflow_d = err_underflow_q | (bus.res_valid & fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            ghr_restore_q    <= '0;
            upd_valid_q      <= 1'b0;
            upd_pc_q         <= '0;
            upd_take_q       <= 1'b0;
            upd_ghr_q        <= '0;
            err_underflow_q  <= 1'b0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            ghr_restore_q    <= ghr_restore_d;
            upd_valid_q      <= upd_valid_d;
            upd_pc_q         <= upd_pc_d;
            upd_take_q       <= upd_take_d;
            upd_ghr_q        <= upd_ghr_d;
            err_underflow_q  <= err_underflow_d;
        end
    end

    assign bus.full           = fifo_full;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.ghr_restore    = ghr_restore_q;
    assign bus.upd_valid      = upd_valid_q;
    assign bus.upd_pc         = upd_pc_q;
    assign bus.upd_take       = upd_take_q;
    assign bus.upd_ghr        = upd_ghr_q;
    assign bus.err_underflow  = err_underflow_q;

`ifdef BRQ_PERF_CNT_EN
    logic [31:0] perf_branches_q, perf_branches_d, perf_mispred_q, perf_mispred_d;

    always_comb begin
        perf_branches_d = perf_branches_q;
        perf_mispred_d  = perf_mispred_q;
        if (res_fire & ~&perf_branches_q) perf_branches_d = perf_branches_q + 32'd1;
        if (mispred & ~&perf_mispred_q)   perf_mispred_d  = perf_mispred_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches_q <= '0;
            perf_mispred_q  <= '0;
        end else begin
            perf_branches_q <= perf_branches_d;
            perf_mispred_q  <= perf_mispred_d;
        end
    end

    assign bus.perf_branches = perf_branches_q;
    assign bus.perf_mispred  = perf_mispred_q;
`endif
endmodule
